// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the instruction/data memory port arbiter.
//   REQ_IF / REQ_D  : requester ids carried through the response tag pipe.
//   RD_LATENCY_MAX  : deepest memory read latency the tag pipe supports.
//   rsp_tag_t/TAG_W : one tag pipe entry, {valid, id}.
package mem_arb_pkg;

  localparam logic REQ_IF         = 1'b0;
  localparam logic REQ_D          = 1'b1;
  localparam int   RD_LATENCY_MAX = 4;

  typedef struct packed {
    logic vld;
    logic id;
  } rsp_tag_t;

  localparam int TAG_W = $bits(rsp_tag_t);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, data port and memory side of
// the arbiter.
//   slave  : arbiter view (takes requests and mem_rdata_i, drives grants,
//            responses and the mem_* strobes).
//   master : environment view (CPU ports plus the RAM macro).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // fetch port
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  // data port
  logic              d_req_i;
  logic              d_we_i;
  logic [BE_W-1:0]   d_be_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  // memory side
  logic              mem_req_o;
  logic              mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/resp_tag_pipe.sv
// resp_tag_pipe: DEPTH-stage shift register of {valid, id} tags that tracks
// reads in flight so returning memory data can be steered to its requester.
//   clk_i  : clock
//   clr_i  : synchronous clear, drops every in-flight tag
//   in_i   : tag pushed this cycle
//   out_o  : tag pushed DEPTH cycles ago
module resp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk_i,
  input  logic     clr_i,
  input  rsp_tag_t in_i,
  output rsp_tag_t out_o
);

  logic [DEPTH-1:0][TAG_W-1:0] tag_pipe;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= in_i;
      for (int i = 1; i < DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign out_o = rsp_tag_t'(tag_pipe[DEPTH-1]);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the CPU
// fetch port and data port. One combinational grant per cycle, data wins
// ties; read data is routed back to the issuer RD_LATENCY cycles later.
//   clk_i   : clock
//   reset_i : synchronous active-high reset
//   bus     : fetch port, data port and memory side (mem_port_arbiter_if.slave)
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to build the fetch
// starvation guard (after MAX_WAIT denied fetch cycles, fetch wins a tie).
// Without it data has strict priority and MAX_WAIT only gets range-checked.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  mem_port_arbiter_if.slave  bus
);

  if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_lat
    $error("mem_port_arbiter: RD_LATENCY out of range 1..4");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_wait
    $error("mem_port_arbiter: MAX_WAIT out of range 1..15");
  end

  logic     promote;
  logic     if_gnt, d_gnt, rd_gnt;
  logic     if_rvalid, d_rvalid;
  rsp_tag_t tag_in, tag_out;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  logic [3:0] wait_cnt;

  // Counts consecutive denied fetch cycles; any fetch grant or a dropped
  // fetch request restarts it. Saturates so promote stays up until fetch wins.
  always_ff @(posedge clk_i) begin
    if (reset_i || !bus.if_req_i || if_gnt) wait_cnt <= '0;
    else if (wait_cnt != MAX_WAIT_C)        wait_cnt <= wait_cnt + 4'd1;
  end

  assign promote = (wait_cnt == MAX_WAIT_C);
`else
  assign promote = 1'b0;
`endif

  // Grants are gated by reset so nothing reaches the RAM while in reset.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset_i) begin
      if (bus.if_req_i && (!bus.d_req_i || promote)) if_gnt = 1'b1;
      else if (bus.d_req_i)                           d_gnt  = 1'b1;
    end
  end

  // Memory side mirrors the winner; idle cycles drive zeros.
  always_comb begin
    bus.mem_req_o   = if_gnt | d_gnt;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (d_gnt) begin
      bus.mem_we_o    = bus.d_we_i;
      bus.mem_be_o    = bus.d_be_i;
      bus.mem_addr_o  = bus.d_addr_i;
      bus.mem_wdata_o = bus.d_wdata_i;
    end else if (if_gnt) begin
      bus.mem_be_o    = '1;
      bus.mem_addr_o  = bus.if_addr_i;
    end
  end

  assign rd_gnt     = d_gnt ? !bus.d_we_i : if_gnt;
  assign tag_in.vld = rd_gnt;
  assign tag_in.id  = d_gnt ? REQ_D : REQ_IF;

  resp_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
    .clk_i (clk_i),
    .clr_i (reset_i),
    .in_i  (tag_in),
    .out_o (tag_out)
  );

  // Reset also masks the pipe output, so a tag pushed just before reset
  // cannot surface during the reset cycle itself.
  assign if_rvalid = !reset_i && tag_out.vld && (tag_out.id == REQ_IF);
  assign d_rvalid  = !reset_i && tag_out.vld && (tag_out.id == REQ_D);

  assign bus.if_gnt_o    = if_gnt;
  assign bus.d_gnt_o     = d_gnt;
  assign bus.if_rvalid_o = if_rvalid;
  assign bus.d_rvalid_o  = d_rvalid;
  assign bus.if_rdata_o  = if_rvalid ? bus.mem_rdata_i : '0;
  assign bus.d_rdata_o   = d_rvalid  ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench. Three arbiters with RD_LATENCY 1, 2
// and 3 see the same request stimulus; each has its own mem_rdata_i.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] rd [3];
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    assign bus.if_req_i    = if_req;
    assign bus.if_addr_i   = if_addr;
    assign bus.d_req_i     = d_req;
    assign bus.d_we_i      = d_we;
    assign bus.d_be_i      = d_be;
    assign bus.d_addr_i    = d_addr;
    assign bus.d_wdata_i   = d_wdata;
    assign bus.mem_rdata_i = rd[g];
    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .RD_LATENCY(g + 1), .MAX_WAIT(4)
    ) u_dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    repeat (n) nxt();
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
    if_addr = 32'h100; d_addr = 32'h200; d_wdata = 32'h0;
    rd[0] = 32'h0; rd[1] = 32'h0; rd[2] = 32'h0;

    // reset with both ports requesting: everything held low
    smp();
    chk("rst if_gnt",    g_dut[0].bus.if_gnt_o,    32'h0);
    chk("rst d_gnt",     g_dut[0].bus.d_gnt_o,     32'h0);
    chk("rst mem_req",   g_dut[0].bus.mem_req_o,   32'h0);
    chk("rst mem_we",    g_dut[0].bus.mem_we_o,    32'h0);
    chk("rst mem_addr",  g_dut[0].bus.mem_addr_o,  32'h0);
    chk("rst if_rvalid", g_dut[2].bus.if_rvalid_o, 32'h0);
    chk("rst d_rdata",   g_dut[2].bus.d_rdata_o,   32'h0);

    // single fetch read, first cycle out of reset
    nxt();
    reset = 1'b0; if_req = 1'b1; d_req = 1'b0; if_addr = 32'h100;
    smp();
    chk("fetch if_gnt",   g_dut[0].bus.if_gnt_o,   32'h1);
    chk("fetch d_gnt",    g_dut[0].bus.d_gnt_o,    32'h0);
    chk("fetch mem_req",  g_dut[0].bus.mem_req_o,  32'h1);
    chk("fetch mem_we",   g_dut[0].bus.mem_we_o,   32'h0);
    chk("fetch mem_be",   g_dut[0].bus.mem_be_o,   32'hF);
    chk("fetch mem_addr", g_dut[0].bus.mem_addr_o, 32'h100);
    nxt();
    if_req = 1'b0; rd[0] = 32'hDEADBEEF;
    smp();
    chk("fetch rvalid N+1", g_dut[0].bus.if_rvalid_o, 32'h1);
    chk("fetch rdata N+1",  g_dut[0].bus.if_rdata_o,  32'hDEADBEEF);
    chk("fetch d_rvalid",   g_dut[0].bus.d_rvalid_o,  32'h0);
    chk("fetch idle req",   g_dut[0].bus.mem_req_o,   32'h0);
    nxt();
    smp();
    chk("fetch rvalid N+2",    g_dut[0].bus.if_rvalid_o, 32'h0);
    chk("fetch rdata N+2",     g_dut[0].bus.if_rdata_o,  32'h0);
    chk("fetch lat2 rvalid",   g_dut[1].bus.if_rvalid_o, 32'h1);
    idle(4);

    // simultaneous requests: data wins until it drops
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h100; d_addr = 32'h200;
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("tie d_gnt",    g_dut[0].bus.d_gnt_o,    32'h1);
      chk("tie if_gnt",   g_dut[0].bus.if_gnt_o,   32'h0);
      chk("tie mem_addr", g_dut[0].bus.mem_addr_o, 32'h200);
      nxt();
    end
    d_req = 1'b0;
    smp();
    chk("tie drop if_gnt",   g_dut[0].bus.if_gnt_o,   32'h1);
    chk("tie drop d_gnt",    g_dut[0].bus.d_gnt_o,    32'h0);
    chk("tie drop mem_addr", g_dut[0].bus.mem_addr_o, 32'h100);
    idle(4);

    // back-to-back data traffic with fetch waiting
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h300; d_addr = 32'h400;
    for (int c = 0; c < 6; c++) begin
      smp();
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk("starve if_gnt", g_dut[0].bus.if_gnt_o, 32'(c == 4));
      chk("starve d_gnt",  g_dut[0].bus.d_gnt_o,  32'(c != 4));
`else
      chk("starve if_gnt", g_dut[0].bus.if_gnt_o, 32'h0);
      chk("starve d_gnt",  g_dut[0].bus.d_gnt_o,  32'h1);
`endif
      nxt();
    end
    idle(4);

    // interleaved reads through the latency-3 arbiter
    if_req = 1'b1; d_req = 1'b0; if_addr = 32'h10;
    smp();
    chk("il c0 if_gnt",    g_dut[2].bus.if_gnt_o,    32'h1);
    chk("il c0 if_rvalid", g_dut[2].bus.if_rvalid_o, 32'h0);
    nxt();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    smp();
    chk("il c1 d_gnt",    g_dut[2].bus.d_gnt_o,    32'h1);
    chk("il c1 mem_addr", g_dut[2].bus.mem_addr_o, 32'h20);
    nxt();
    if_req = 1'b1; d_req = 1'b0; if_addr = 32'h30;
    smp();
    chk("il c2 if_gnt", g_dut[2].bus.if_gnt_o, 32'h1);
    nxt();
    if_req = 1'b0; rd[2] = 32'hA0;
    smp();
    chk("il c3 if_rvalid", g_dut[2].bus.if_rvalid_o, 32'h1);
    chk("il c3 if_rdata",  g_dut[2].bus.if_rdata_o,  32'hA0);
    chk("il c3 d_rvalid",  g_dut[2].bus.d_rvalid_o,  32'h0);
    nxt();
    rd[2] = 32'hB0;
    smp();
    chk("il c4 d_rvalid",  g_dut[2].bus.d_rvalid_o,  32'h1);
    chk("il c4 d_rdata",   g_dut[2].bus.d_rdata_o,   32'hB0);
    chk("il c4 if_rvalid", g_dut[2].bus.if_rvalid_o, 32'h0);
    chk("il c4 if_rdata",  g_dut[2].bus.if_rdata_o,  32'h0);
    nxt();
    rd[2] = 32'hC0;
    smp();
    chk("il c5 if_rvalid", g_dut[2].bus.if_rvalid_o, 32'h1);
    chk("il c5 if_rdata",  g_dut[2].bus.if_rdata_o,  32'hC0);
    chk("il c5 d_rvalid",  g_dut[2].bus.d_rvalid_o,  32'h0);
    nxt();
    smp();
    chk("il c6 if_rvalid", g_dut[2].bus.if_rvalid_o, 32'h0);
    chk("il c6 d_rvalid",  g_dut[2].bus.d_rvalid_o,  32'h0);
    idle(4);

    // data write: strobes in the grant cycle, no rvalid on any latency
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'h12345678; d_addr = 32'h40;
    smp();
    chk("wr d_gnt",     g_dut[0].bus.d_gnt_o,     32'h1);
    chk("wr mem_we",    g_dut[0].bus.mem_we_o,    32'h1);
    chk("wr mem_be",    g_dut[0].bus.mem_be_o,    32'h3);
    chk("wr mem_wdata", g_dut[0].bus.mem_wdata_o, 32'h12345678);
    chk("wr mem_addr",  g_dut[0].bus.mem_addr_o,  32'h40);
    nxt();
    d_req = 1'b0; d_we = 1'b0;
    smp();
    chk("wr lat1 d_rvalid", g_dut[0].bus.d_rvalid_o, 32'h0);
    nxt();
    smp();
    chk("wr lat2 d_rvalid", g_dut[1].bus.d_rvalid_o, 32'h0);
    nxt();
    smp();
    chk("wr lat3 d_rvalid", g_dut[2].bus.d_rvalid_o, 32'h0);
    nxt();

    // reset one cycle after a data read: the read never returns
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h50;
    rd[0] = 32'h5555AAAA; rd[1] = 32'h5555AAAA; rd[2] = 32'h5555AAAA;
    smp();
    chk("mid d_gnt", g_dut[1].bus.d_gnt_o, 32'h1);
    nxt();
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1;
    smp();
    chk("mid rst d_gnt",    g_dut[1].bus.d_gnt_o,    32'h0);
    chk("mid rst if_gnt",   g_dut[1].bus.if_gnt_o,   32'h0);
    chk("mid rst mem_req",  g_dut[1].bus.mem_req_o,  32'h0);
    chk("mid rst lat1 rv",  g_dut[0].bus.d_rvalid_o, 32'h0);
    chk("mid rst lat1 rd",  g_dut[0].bus.d_rdata_o,  32'h0);
    nxt();
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
    smp();
    chk("mid lat2 d_rvalid", g_dut[1].bus.d_rvalid_o, 32'h0);
    chk("mid lat2 d_rdata",  g_dut[1].bus.d_rdata_o,  32'h0);
    nxt();
    smp();
    chk("mid lat3 d_rvalid", g_dut[2].bus.d_rvalid_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port synchronous memory between the CPU's instruction-fetch port and data port. Lets a unified instruction/data RAM replace the split memories. Sits between the `cpu` memory ports and the RAM macro. Grants one access per cycle, routes read data back to the issuing port after a fixed latency, and prevents fetch starvation under back-to-back data traffic.

## Interface
- `ADDR_W`, 32, address width in bits.
- `DATA_W`, 32, data width in bits; byte enables are `DATA_W/8` bits wide.
- `RD_LATENCY`, 1, memory read latency in cycles; legal range 1..4.
- `MAX_WAIT`, 4, consecutive denied fetch cycles before fetch is promoted; legal range 1..15.

Clock and reset (already decided): one clock; reset is synchronous and active-high.
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `reset_i`  in  1  synchronous, active-high reset.

Fetch port:
- `if_req_i`  in  1  fetch read request.
- `if_addr_i`  in  ADDR_W  fetch address.
- `if_gnt_o`  out  1  fetch request accepted this cycle.
- `if_rvalid_o`  out  1  fetch read data valid.
- `if_rdata_o`  out  DATA_W  fetch read data.

Data port:
- `d_req_i`  in  1  data access request.
- `d_we_i`  in  1  1 = write, 0 = read.
- `d_be_i`  in  DATA_W/8  byte enables for writes.
- `d_addr_i`  in  ADDR_W  data address.
- `d_wdata_i`  in  DATA_W  write data.
- `d_gnt_o`  out  1  data request accepted this cycle.
- `d_rvalid_o`  out  1  data read data valid.
- `d_rdata_o`  out  DATA_W  data read data.

Memory side:
- `mem_req_o`  out  1  access strobe.
- `mem_we_o`  out  1  write strobe.
- `mem_be_o`  out  DATA_W/8  byte enables.
- `mem_addr_o`  out  ADDR_W  address.
- `mem_wdata_o`  out  DATA_W  write data.
- `mem_rdata_i`  in  DATA_W  read data, valid `RD_LATENCY` cycles after the read.

## Operation
- Requester handshake:
  - The requester holds req, addr, we, be and wdata stable until it sees its gnt high.
  - The access transfers on the cycle where req and gnt are both high.
- Arbitration, combinational from current inputs and state:
  - Only one requester active: that requester is granted.
  - Both active: data wins, except when `promote` is set, in which case fetch wins.
  - At most one gnt is high in any cycle.
- Memory side: `mem_*` mirror the winning requester. `mem_req_o` = `if_gnt_o | d_gnt_o`. Fetch is always a read: `mem_we_o`=0 and `mem_be_o`=all-ones.
- Response tag pipe:
  - Depth `RD_LATENCY`, entries {valid, id}.
  - A granted read pushes {1, id}; any other cycle pushes {0, x}.
  - The pipe output drives `if_rvalid_o` / `d_rvalid_o` by id.
  - Writes produce no rvalid.
- Read data: `*_rdata_o` = `mem_rdata_i` when the matching rvalid is high, otherwise 0.
- Back-to-back accesses: one grant per cycle, no bubbles, mixed reads and writes allowed.

## Timing
- Grant latency is 0 cycles: gnt is combinational in the request cycle.
- A read granted in cycle N gives rvalid in cycle N+`RD_LATENCY`, exactly one cycle wide.
- Reset (`reset_i`=1):
  - Both gnt outputs, `mem_req_o` and `mem_we_o` are forced to 0.
  - Tag pipe cleared, so in-flight reads are discarded: no rvalid after reset, even for reads granted before it.
  - `wait_cnt`=0, `promote`=0.
  - All rdata outputs = 0.
- First grant possible in the first cycle with `reset_i`=0.
- `wait_cnt` update each cycle:
  - +1 when `if_req_i`=1 and `if_gnt_o`=0, saturating at `MAX_WAIT`.
  - Cleared on any fetch grant, or when `if_req_i`=0.
  - `promote` = (`wait_cnt` == `MAX_WAIT`).
- A fetch-request drop while waiting is a protocol violation; the counter clears and nothing else happens.
- Read and write to the same address in consecutive cycles are handled by memory order; the arbiter does not reorder.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - `wait_cnt` and `promote` are present, as described above.
  - Worst-case fetch wait is `MAX_WAIT` cycles.
- Undefined:
  - Strict data priority; the counter logic is not compiled in.
  - `MAX_WAIT` is ignored.
  - Fetch can starve indefinitely.

## Structure
- Shared package `mem_arb_pkg`:
  - Requester id constants `REQ_IF`=1'b0 and `REQ_D`=1'b1.
  - `RD_LATENCY_MAX`=4.
  - Tag struct/width constant.
- One sub-module, `resp_tag_pipe`: a parameterised shift register of {valid, id} with synchronous clear.
- Arbitration and the counter stay in the top module.

## Test plan
- Reset mid-flight: grant a data read, then assert `reset_i` 1 cycle later; with `RD_LATENCY`=2 -> no `d_rvalid_o` ever; all outputs 0 while in reset.
- Single fetch read: `if_req_i`=1, `if_addr_i`=0x100, `mem_rdata_i`=0xDEADBEEF at N+1 -> `if_gnt_o`=1 at N; `if_rvalid_o`=1 and `if_rdata_o`=0xDEADBEEF at N+1 only.
- Simultaneous requests, guard off: both requesting, `d_addr_i`=0x200 -> `d_gnt_o`=1, `mem_addr_o`=0x200; fetch granted only in the first cycle `d_req_i`=0.
- Starvation guard on, `MAX_WAIT`=4: `d_req_i` held high, `if_req_i` high from cycle 0 -> `if_gnt_o`=1 in cycle 4, data granted in cycles 0-3 and 5.
- Interleaved reads, `RD_LATENCY`=3: fetch, data, fetch granted in cycles 0, 1, 2 -> `if_rvalid_o` at 3, `d_rvalid_o` at 4, `if_rvalid_o` at 5, each carrying the data for its own cycle.
- Data write: `d_we_i`=1, `d_be_i`=4'b0011, `d_wdata_i`=0x12345678 -> `mem_we_o`=1 and `mem_be_o`=0011 in the grant cycle; no rvalid follows.
